// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD read and write paths:
// FSM state codes, default pin timing, RS encodings.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t IDLE  = 3'd0;
  localparam lcd_state_t SETUP = 3'd1;
  localparam lcd_state_t E_HI  = 3'd2;
  localparam lcd_state_t E_LO  = 3'd3;
  localparam lcd_state_t DONE  = 3'd4;

  // Defaults for a 50 MHz clock
  localparam int unsigned SETUP_CYC_DEF  = 3;
  localparam int unsigned E_HIGH_CYC_DEF = 24;
  localparam int unsigned E_LOW_CYC_DEF  = 26;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Timer load value: a state lasting cyc cycles starts at cyc-1 and exits on zero
  function automatic logic [7:0] cyc_load(input int unsigned cyc);
    return 8'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_cyc_timer.sv
// Loadable 8-bit down-counter shared by the timed LCD states; zero flags expiry.
module lcd_cyc_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  assign zero = (cnt_reg == 8'd0);

endmodule

// File: rtl/lcd_reader.sv
// Read-side transactor for the 4-bit HD44780 LCD port: busy/address or data byte.
// Optional busy polling is built when LCD_READER_POLL_EN is defined.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
  parameter int unsigned E_HIGH_CYC = E_HIGH_CYC_DEF,
  parameter int unsigned E_LOW_CYC  = E_LOW_CYC_DEF,
  parameter logic [15:0] POLL_MAX   = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  output logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       timeout,
  output logic       bus_own,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [3:0] lcd_dat_i
);

  lcd_state_t state_reg, state_next;
  logic       nib_reg, nib_next;
  logic       rs_reg;
  logic [7:0] data_reg;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_zero;
  logic       byte_again;

  lcd_cyc_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next = state_reg;
    nib_next   = nib_reg;
    tmr_load   = 1'b0;
    tmr_val    = cyc_load(SETUP_CYC);
    case (state_reg)
      IDLE: if (req) begin
        state_next = SETUP;
        tmr_load   = 1'b1;
        tmr_val    = cyc_load(SETUP_CYC);
      end
      SETUP: if (tmr_zero) begin
        state_next = E_HI;
        nib_next   = 1'b0;
        tmr_load   = 1'b1;
        tmr_val    = cyc_load(E_HIGH_CYC);
      end
      E_HI: if (tmr_zero) begin
        state_next = E_LO;
        tmr_load   = 1'b1;
        tmr_val    = cyc_load(E_LOW_CYC);
      end
      E_LO: if (tmr_zero) begin
        // Second nibble, or another poll byte: skip setup, RS/RW stay put
        if (!nib_reg || byte_again) begin
          state_next = E_HI;
          nib_next   = !nib_reg;
          tmr_load   = 1'b1;
          tmr_val    = cyc_load(E_HIGH_CYC);
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      nib_reg   <= 1'b0;
      rs_reg    <= RS_CMD;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      nib_reg   <= nib_next;
      if (state_reg == IDLE && req) begin
        rs_reg <= rs_sel;
      end
      if (state_reg == E_HI && tmr_zero) begin
        if (nib_reg) data_reg[3:0] <= lcd_dat_i;
        else         data_reg[7:4] <= lcd_dat_i;
      end
    end
  end

`ifdef LCD_READER_POLL_EN
  logic        poll_reg;
  logic [15:0] poll_cnt_reg;
  logic        timeout_reg;
  logic        poll_busy;
  logic        poll_at_max;

  // BF is data[7], already captured from nibble 0 when the byte ends
  assign poll_busy   = poll_reg && (rs_reg == RS_CMD) && data_reg[7];
  assign poll_at_max = ((poll_cnt_reg + 16'd1) == POLL_MAX);
  assign byte_again  = poll_busy && !poll_at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_reg     <= 1'b0;
      poll_cnt_reg <= 16'd0;
      timeout_reg  <= 1'b0;
    end else if (state_reg == IDLE && req) begin
      poll_reg     <= poll;
      poll_cnt_reg <= 16'd0;
    end else if (state_reg == E_LO && tmr_zero && nib_reg) begin
      if (poll_busy) poll_cnt_reg <= poll_cnt_reg + 16'd1;
      timeout_reg <= poll_busy && poll_at_max;
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_poll;
  assign unused_poll = poll;
  assign byte_again  = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign ready   = (state_reg == IDLE);
  assign valid   = (state_reg == DONE);
  assign data    = data_reg;
  assign bus_own = (state_reg != IDLE);
  assign lcd_e   = (state_reg == E_HI);
  assign lcd_rw  = (state_reg != IDLE);
  assign lcd_rs  = (state_reg != IDLE) && rs_reg;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader with a nibble-serving LCD model; poll cases
// follow LCD_READER_POLL_EN.
module tb_lcd_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       rs_sel;
  logic       poll;
  logic       ready;
  logic       valid;
  logic [7:0] data;
  logic       timeout;
  logic       bus_own;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_dat_i;

  always #5 clk = ~clk;

  lcd_reader #(
    .SETUP_CYC  (3),
    .E_HIGH_CYC (24),
    .E_LOW_CYC  (26),
    .POLL_MAX   (16'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rs_sel    (rs_sel),
    .poll      (poll),
    .ready     (ready),
    .valid     (valid),
    .data      (data),
    .timeout   (timeout),
    .bus_own   (bus_own),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_dat_i (lcd_dat_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // LCD model and pin monitor
  logic [7:0] rd_bytes [0:7];
  int   now = 0;
  int   pulse_idx = 0;
  int   rise_t = 0;
  int   e_w = 0;
  int   rs_viol = 0;
  int   acc_cnt = 0;
  int   acc_last = 0;
  int   acc_prev = 0;
  int   vcnt = 0;
  logic e_q = 1'b0;
  logic abort = 1'b0;
  logic exp_rs = 1'b0;

  always @(posedge clk) now <= now + 1;

  always @(negedge clk) begin
    int idx;
    if (req && ready && !rst) begin
      acc_cnt++;
      acc_prev = acc_last;
      acc_last = now + 1;
    end
    if (valid) vcnt++;
    if (bus_own && (lcd_rw !== 1'b1 || lcd_rs !== exp_rs || ready)) rs_viol++;
    if (lcd_e && !e_q) begin
      if (pulse_idx == 0) rise_t = now + 1;
      idx = (pulse_idx / 2 > 7) ? 7 : pulse_idx / 2;
      lcd_dat_i = pulse_idx[0] ? rd_bytes[idx][3:0] : rd_bytes[idx][7:4];
      pulse_idx++;
      e_w = 0;
    end
    if (lcd_e) e_w++;
    if (!lcd_e && e_q && !abort) check("e_width", e_w, 24);
    e_q = lcd_e;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic rs, input logic pl,
                         input int exp_lat, input logic [7:0] exp_data,
                         input logic exp_to, input int exp_pulses);
    int acc;
    int lat;
    pulse_idx = 0;
    rs_viol   = 0;
    exp_rs    = rs;
    req = 1'b1; rs_sel = rs; poll = pl;
    tick();
    req = 1'b0;
    acc = acc_last;
    check({tag, "_ready_low"}, int'(ready), 0);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if (valid) begin
        lat = now + 1 - acc;
        break;
      end
      tick();
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, int'(data), int'(exp_data));
    check({tag, "_timeout"}, int'(timeout), int'(exp_to));
    check({tag, "_e_pulses"}, pulse_idx, exp_pulses);
    check({tag, "_e_first_rise"}, rise_t - acc, 4);
    check({tag, "_rs_rw_stable"}, rs_viol, 0);
    tick();
    check({tag, "_idle_ready"}, int'(ready), 1);
    check({tag, "_idle_bus"}, int'({bus_own, lcd_rw, lcd_e}), 0);
    $display("read %s rs=%0d poll=%0d data=%02h timeout=%0d latency=%0d pulses=%0d",
             tag, rs, pl, data, timeout, lat, pulse_idx);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int a0;
    rst = 1'b1; req = 1'b0; rs_sel = 1'b0; poll = 1'b0; lcd_dat_i = 4'h0;
    for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h00;
    repeat (3) tick();
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_bus_own", int'(bus_own), 0);
    check("rst_lcd_e", int'(lcd_e), 0);
    check("rst_lcd_rs", int'(lcd_rs), 0);
    check("rst_lcd_rw", int'(lcd_rw), 0);
    check("rst_data", int'(data), 0);
    rst = 1'b0;
    tick();

    // Plain status read
    rd_bytes[0] = 8'h3A;
    do_read("status", 1'b0, 1'b0, 104, 8'h3A, 1'b0, 2);

    // Data read
    rd_bytes[0] = 8'hC5;
    do_read("data", 1'b1, 1'b0, 104, 8'hC5, 1'b0, 2);

    // Handshake: req held for 200 cycles gives accepts at +0 and +105 only
    for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h3A;
    pulse_idx = 0; rs_viol = 0; exp_rs = 1'b0;
    a0 = acc_cnt; v0 = vcnt;
    req = 1'b1; rs_sel = 1'b0; poll = 1'b0;
    repeat (200) tick();
    req = 1'b0;
    for (int i = 0; i < 300 && vcnt - v0 < 2; i++) tick();
    tick();
    check("hs_accepts", acc_cnt - a0, 2);
    check("hs_spacing", acc_last - acc_prev, 105);
    check("hs_valids", vcnt - v0, 2);
    check("hs_data", int'(data), 8'h3A);
    check("hs_rs_rw_stable", rs_viol, 0);
    $display("read handshake accepts=%0d spacing=%0d valids=%0d data=%02h",
             acc_cnt - a0, acc_last - acc_prev, vcnt - v0, data);

    // Reset during the first E pulse
    rd_bytes[0] = 8'h77;
    pulse_idx = 0;
    req = 1'b1; rs_sel = 1'b1; poll = 1'b0; exp_rs = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 50 && !lcd_e; i++) tick();
    check("abort_in_e_hi", int'(lcd_e), 1);
    repeat (5) tick();
    abort = 1'b1;
    rst = 1'b1;
    tick();
    check("abort_lcd_e", int'(lcd_e), 0);
    check("abort_bus_own", int'(bus_own), 0);
    check("abort_ready", int'(ready), 1);
    rst = 1'b0;
    v0 = vcnt;
    repeat (150) tick();
    check("abort_no_valid", vcnt - v0, 0);
    abort = 1'b0;
    $display("read abort lcd_e=%0d bus_own=%0d ready=%0d valids=%0d",
             lcd_e, bus_own, ready, vcnt - v0);
    rd_bytes[0] = 8'h5E;
    do_read("after_abort", 1'b0, 1'b0, 104, 8'h5E, 1'b0, 2);

    // Busy polling: BF=1 three times, then BF=0 with address 7'h05
    rd_bytes[0] = 8'h81; rd_bytes[1] = 8'h82; rd_bytes[2] = 8'h83; rd_bytes[3] = 8'h05;
`ifdef LCD_READER_POLL_EN
    do_read("poll", 1'b0, 1'b1, 404, 8'h05, 1'b0, 8);
`else
    do_read("poll", 1'b0, 1'b1, 104, 8'h81, 1'b0, 2);
`endif

    // Busy flag stuck high
    for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h8F;
`ifdef LCD_READER_POLL_EN
    do_read("poll_timeout", 1'b0, 1'b1, 404, 8'h8F, 1'b1, 8);
`else
    do_read("poll_timeout", 1'b0, 1'b1, 104, 8'h8F, 1'b0, 2);
`endif

    // A plain read after a timeout clears the flag
    rd_bytes[0] = 8'h12;
    do_read("post_timeout", 1'b1, 1'b0, 104, 8'h12, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
